// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy encoding and per-stage word layouts.
package pipe_pkg;

  // Number of words held by an inter-stage register.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // Control-field widths (LSBs of each stage word, zeroed on bubbles).
  localparam int IF_ID_CTRL_W = 1;
  localparam int ID_EX_CTRL_W = 8;
  localparam int EX_ME_CTRL_W = 3;
  localparam int ME_WB_CTRL_W = 2;

  // Total packed-word widths per stage.
  localparam int IF_ID_W = 64;
  localparam int ID_EX_W = 120;
  localparam int EX_ME_W = 72;
  localparam int ME_WB_W = 71;

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and an optional 2-entry skid buffer giving a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = EX_ME_W,
  parameter int CTRL_W = EX_ME_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_t              r_occ;
  occ_t              w_occ_n;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_n;
  logic [DATA_W-1:0] w_skid;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_out_valid = (r_occ != OCC_EMPTY);
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;

  // Next occupancy and main-register contents; flush overrides everything.
  always_comb begin
    w_occ_n  = r_occ;
    w_main_n = r_main;
    if (flush) begin
      w_occ_n                = OCC_EMPTY;
      w_main_n[CTRL_W-1:0]   = '0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_in_fire) begin
            w_occ_n  = OCC_ONE;
            w_main_n = in_data;
          end
        end
        OCC_ONE: begin
          // In-fire without out-fire only happens with a skid entry present.
          if (w_in_fire && w_out_fire) w_main_n = in_data;
          else if (w_in_fire)          w_occ_n  = OCC_TWO;
          else if (w_out_fire)         w_occ_n  = OCC_EMPTY;
        end
        OCC_TWO: begin
          if (w_out_fire) begin
            w_occ_n  = OCC_ONE;
            w_main_n = w_skid;
          end
        end
        default: w_occ_n = OCC_EMPTY;
      endcase
    end
  end

  // Main register and occupancy; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ  <= OCC_EMPTY;
      r_main <= '0;
    end else begin
      r_occ  <= w_occ_n;
      r_main <= w_main_n;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] r_skid;
      logic              r_in_rdy;

      // Skid entry catches the word accepted while downstream stalls.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          r_skid <= '0;
        else if (flush)
          r_skid[CTRL_W-1:0] <= '0;
        else if (r_occ == OCC_ONE && w_in_fire && !w_out_fire)
          r_skid <= in_data;
      end

      // Registered ready breaks the out_ready -> in_ready path.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_in_rdy <= 1'b1;
        else      r_in_rdy <= (w_occ_n != OCC_TWO);
      end

      assign w_skid     = r_skid;
      assign w_in_ready = r_in_rdy;
    end else begin : g_noskid
      assign w_skid     = '0;
      assign w_in_ready = !w_out_valid || out_ready;
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign occupancy = r_occ;
  // Bubbles never leak control bits downstream.
  assign out_data  = {r_main[DATA_W-1:CTRL_W],
                      w_out_valid ? r_main[CTRL_W-1:0] : {CTRL_W{1'b0}}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances driven in lockstep,
// each with its own FIFO scoreboard, plus a table of stall/flush vectors.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = 72;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         ir1, ov1, ir0, ov0;
  logic [W-1:0] od1, od0;
  logic [1:0]   oc1, oc0;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic [1:0]   e_occ;
    logic         e_irdy;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .CTRL_W(3), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(oc1));

  pipe_stage_reg #(.DATA_W(W), .CTRL_W(3), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .flush(flush), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(oc0));

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Pre-edge evaluation: compare outputs against the models, then update them.
  task automatic sb_eval();
    logic [W-1:0] e;
    chk("u1 occ", W'(oc1), W'(q1.size()));
    chk("u1 out_valid", W'(ov1), W'(q1.size() != 0));
    chk("u1 in_ready", W'(ir1), W'(q1.size() != 2));
    if (!ov1) chk("u1 bubble ctrl", W'(od1[2:0]), '0);
    if (ov1 && out_ready) begin
      if (q1.size() == 0) chk("u1 spurious out", W'(ov1), '0);
      else begin e = q1.pop_front(); chk("u1 data", od1, e); end
    end
    if (flush) q1.delete();
    else if (in_valid && ir1) q1.push_back(in_data);

    chk("u0 occ", W'(oc0), W'(q0.size()));
    chk("u0 out_valid", W'(ov0), W'(q0.size() != 0));
    chk("u0 in_ready", W'(ir0), W'((q0.size() == 0) || out_ready));
    if (!ov0) chk("u0 bubble ctrl", W'(od0[2:0]), '0);
    if (ov0 && out_ready) begin
      if (q0.size() == 0) chk("u0 spurious out", W'(ov0), '0);
      else begin e = q0.pop_front(); chk("u0 data", od0, e); end
    end
    if (flush) q0.delete();
    else if (in_valid && ir0) q0.push_back(in_data);
  endtask

  task automatic step();
    #1;
    sb_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " u1 out_valid"}, W'(ov1), '0);
    chk({tag, " u1 out_data"}, od1, '0);
    chk({tag, " u1 in_ready"}, W'(ir1), W'(1));
    chk({tag, " u1 occ"}, W'(oc1), '0);
    chk({tag, " u0 out_valid"}, W'(ov0), '0);
    chk({tag, " u0 out_data"}, od0, '0);
    chk({tag, " u0 in_ready"}, W'(ir0), W'(1));
    chk({tag, " u0 occ"}, W'(oc0), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            iv    data                        ordy  fl    occ   irdy
    tbl[0]  = '{1'b1, 72'hA0_0000_0000_0000_00A7, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[1]  = '{1'b1, 72'hB0_0000_0000_0000_00B5, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[2]  = '{1'b1, 72'hC0_0000_0000_0000_00C3, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 72'hC0_0000_0000_0000_00C3, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[4]  = '{1'b1, 72'hC0_0000_0000_0000_00C3, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[5]  = '{1'b0, 72'h0,                      1'b1, 1'b0, 2'd0, 1'b1};
    tbl[6]  = '{1'b1, 72'hD0_0000_0000_0000_00D7, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 72'hE0_0000_0000_0000_00E6, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 72'h5,                      1'b0, 1'b1, 2'd0, 1'b1};
    tbl[9]  = '{1'b0, 72'h0,                      1'b1, 1'b0, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 72'hF0_0000_0000_0000_00F1, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[11] = '{1'b1, 72'h90_0000_0000_0000_0092, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[12] = '{1'b0, 72'h0,                      1'b1, 1'b0, 2'd0, 1'b1};

    // Reset held with a live all-ones word on the input.
    #1;
    rst = 1'b0; in_valid = 1'b1; in_data = '1; out_ready = 1'b0;
    #11;
    chk_reset_vals("reset");
    #1;
    rst = 1'b1;
    step();
    chk("reset exit u1 data", od1, '1);
    chk("reset exit u0 data", od0, '1);

    // Back-to-back streaming.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = W'(k);
      step();
      chk("stream u1 word", {od1[W-2:0], ov1}, {W'(k), 1'b1} >> 0 == 0 ? '0 : {W'(k) << 1} | W'(1));
      chk("stream u0 word", od0, W'(k));
    end
    in_valid = 1'b0;
    step();

    // Stall, full-buffer flush, and ONE-state pass-through vectors.
    for (int i = 0; i < 13; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      step();
      chk($sformatf("tbl[%0d] u1 occ", i), W'(oc1), W'(tbl[i].e_occ));
      chk($sformatf("tbl[%0d] u1 in_ready", i), W'(ir1), W'(tbl[i].e_irdy));
    end
    flush = 1'b0;

    // Asynchronous reset while the skid buffer is full.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 72'h11_0000_0000_0000_0016;
    step();
    in_data   = 72'h22_0000_0000_0000_0025;
    step();
    chk("pre-reset u1 occ", W'(oc1), W'(2));
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("async reset");
    q1.delete();
    q0.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Fresh traffic after reset; nothing from before may reappear.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 72'h33_0000_0000_0000_0034;
    step();
    in_valid = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
